cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Single-owner arbiter and sequencer for the shared multicycle main memory.
- Serialises I-cache line fills, D-cache line fills and D-side write-through stores.
- Drives the memory request port and the cache fill write ports.
- Generates the I-side and D-side stall signals that the hazard/stall logic merges into PC-hold and pipeline-freeze.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width
- WORDS_PER_BLK, 8, words per cache line (line = 16 bytes)
- MEM_LAT, 4, cycles from read issue to mem_data_valid; also write occupancy

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_miss  in  1  IF stage missed; level, held until serviced
- icache_miss_addr  in  ADDR_W  missing instruction address
- dcache_miss  in  1  MEM stage load/store missed; level
- dcache_miss_addr  in  ADDR_W  missing data address
- dcache_wr  in  1  store write-through request; level
- dcache_wr_addr  in  ADDR_W  store address
- dcache_wr_data  in  DATA_W  store data
- mem_en  out  1  memory request valid
- mem_wr  out  1  1 = write, 0 = read (qualified by mem_en)
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read return data
- mem_data_valid  in  1  mem_rdata valid this cycle
- fill_data  out  DATA_W  mem_rdata forwarded
- fill_word  out  3  word index within line for fill_data
- fill_we_i  out  1  write fill_data into I-cache data array
- fill_we_d  out  1  write fill_data into D-cache data array
- tag_we_i  out  1  one-cycle pulse: install tag/valid in I-cache
- tag_we_d  out  1  one-cycle pulse: install tag/valid in D-cache
- i_stall  out  1  freeze fetch
- d_stall  out  1  freeze the whole pipeline
- busy  out  1  FSM not IDLE

Behaviour:
- Reset: state IDLE; issue_cnt = 0; recv_cnt = 0; wait_cnt = 0. All outputs 0 except combinational stalls, which follow the Stall equations below.
- States: IDLE, D_FILL, I_FILL, WRITE, DONE.
- Priority from IDLE, evaluated each cycle:
  - dcache_miss → D_FILL.
  - else dcache_wr → WRITE.
  - else icache_miss → I_FILL.
  - D-side wins because it belongs to the older instruction.
- On grant, latch the base address: req_addr with bits [3:0] cleared (fills) or the full store address (writes). Inputs are ignored until the FSM returns to IDLE.
- Fill issue:
  - For issue_cnt = 0..WORDS_PER_BLK-1, one read per cycle: mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt.
  - The first issue is in the cycle after the grant.
- Fill receive:
  - Each mem_data_valid writes fill_data = mem_rdata at fill_word = recv_cnt, with fill_we_i or fill_we_d per state, then recv_cnt increments.
  - Receive overlaps issue (pipelined memory).
- Fill completion:
  - When recv_cnt reaches WORDS_PER_BLK, go to DONE.
  - DONE pulses tag_we_i or tag_we_d for one cycle, then returns to IDLE.
  - The requester's miss deasserts the cycle after the tag write, so it is not re-granted.
- Unsolicited data: mem_data_valid in IDLE or WRITE is ignored, with no write enables.
- WRITE:
  - mem_en = 1, mem_wr = 1 for exactly one cycle with the latched address/data.
  - wait_cnt then counts MEM_LAT-1 further cycles; then go to DONE (no tag pulse) → IDLE.
- Stalls:
  - d_stall = dcache_miss | dcache_wr | (state != IDLE & state_is_D).
  - It deasserts in the DONE cycle for the serviced D request.
  - i_stall = icache_miss | d_stall.
- Line fill latency: grant + 8 issues + MEM_LAT-1 tail + DONE. Minimum 1 + 8 + 3 + 1 = 13 cycles from IDLE to IDLE.
- Simultaneous requests: an I miss pending during a D fill waits; it is granted in the IDLE cycle after DONE if no new D request is present. Starvation of I is accepted because D requests are bounded by pipeline freeze.
- Counter widths: issue_cnt and recv_cnt are $clog2(WORDS_PER_BLK)+1 bits, so the terminal value 8 is representable. Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-operation: immediate return to IDLE and all counters cleared. Returning in-flight memory data is dropped by the IDLE ignore rule.

Decomposition:
- Shared package (cpu_pkg): state encoding (3-bit localparams), WORDS_PER_BLK, MEM_LAT, line-offset mask.
- One natural sub-module: fill_counter (issue/receive counter pair with terminal-count flags), instantiated once and reused by both fill states.

Test Plan:
- I miss alone at addr 0x0124: expect reads at 0x0120, 0x0122 … 0x012E on 8 consecutive cycles; fill_we_i with fill_word 0..7; tag_we_i pulse; i_stall high until DONE; total 13 cycles.
- icache_miss and dcache_miss raised in the same cycle: D fill serviced first (fill_we_d only); I fill starts in the IDLE cycle after the D DONE; d_stall drops before i_stall.
- Store 0xBEEF to 0x0040: one cycle with mem_en = 1, mem_wr = 1, mem_addr = 0x0040, mem_wdata = 0xBEEF; d_stall high for MEM_LAT + 1 cycles; no tag pulse.
- Miss address 0xFFFA: fill addresses 0xFFF0..0xFFFE, no wrap error; issue_cnt terminates at 8.
- rst_n pulsed low at the 4th fill issue: outputs zero asynchronously; late mem_data_valid produces no write enables; a new request after reset is serviced normally.
- Spurious mem_data_valid while IDLE: no fill_we_*, state stays IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, default line
// geometry / memory latency, and line-offset helper.
package cache_mem_arbiter_pkg;
  localparam int DEF_WORDS_PER_BLK = 8;
  localparam int DEF_MEM_LAT       = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_FILL = 3'd1,
    ST_I_FILL = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } arbState_t;

  // Number of byte-offset bits inside one line of 16-bit words.
  function automatic int lineOffBits(input int words);
    return $clog2(words * 2);
  endfunction
endpackage

// File: rtl/cache_mem_arbiter_fill_counter.sv
// Issue/receive counter pair for a line fill, with terminal-count flags.
module cache_mem_arbiter_fill_counter #(
  parameter  int WORDS_PER_BLK = 8,
  localparam int CW            = $clog2(WORDS_PER_BLK) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          issueInc,
  input  logic          recvInc,
  output logic [CW-1:0] issueCnt,
  output logic [CW-1:0] recvCnt,
  output logic          issueDone,
  output logic          recvLast
);
  assign issueDone = (issueCnt == CW'(WORDS_PER_BLK));
  assign recvLast  = (recvCnt == CW'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueCnt <= '0;
      recvCnt  <= '0;
    end else if (clear) begin
      issueCnt <= '0;
      recvCnt  <= '0;
    end else begin
      if (issueInc && !issueDone) issueCnt <= issueCnt + CW'(1);
      if (recvInc && (recvCnt != CW'(WORDS_PER_BLK))) recvCnt <= recvCnt + CW'(1);
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-owner arbiter for the shared multicycle memory: serialises D fills,
// D write-through stores and I fills, drives cache fill ports and stalls.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter int MEM_LAT       = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [DATA_W-1:0] dcache_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              i_stall,
  output logic              d_stall,
  output logic              busy
);
  localparam int CW    = $clog2(WORDS_PER_BLK) + 1;
  localparam int WW    = $clog2(MEM_LAT) + 1;
  localparam int OFF_W = lineOffBits(WORDS_PER_BLK);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  function automatic logic [ADDR_W-1:0] lineBase(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  arbState_t         state;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic [WW-1:0]     waitCnt;
  logic [1:0]        doneTag;  // [1] = I-cache tag install, [0] = D-cache
  logic [CW-1:0]     issueCnt;
  logic [CW-1:0]     recvCnt;
  logic              issueDone;
  logic              recvLast;
  logic              inFill;
  logic              issueNow;
  logic              fillAccept;
  logic              memWrNow;

  assign inFill     = (state == ST_D_FILL) || (state == ST_I_FILL);
  assign issueNow   = inFill && !issueDone;
  assign fillAccept = inFill && mem_data_valid;
  assign memWrNow   = (state == ST_WRITE) && (waitCnt == '0);

  cache_mem_arbiter_fill_counter #(.WORDS_PER_BLK(WORDS_PER_BLK)) fillCnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == ST_IDLE),
    .issueInc (issueNow),
    .recvInc  (fillAccept),
    .issueCnt (issueCnt),
    .recvCnt  (recvCnt),
    .issueDone(issueDone),
    .recvLast (recvLast)
  );

  // Request latch: captured only on grant, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (dcache_miss) begin
        reqAddr <= lineBase(dcache_miss_addr);
      end else if (dcache_wr) begin
        reqAddr <= dcache_wr_addr;
        reqData <= dcache_wr_data;
      end else if (icache_miss) begin
        reqAddr <= lineBase(icache_miss_addr);
      end
    end
  end

  // Sequencer: D requests outrank I because they belong to the older instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
      doneTag <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          waitCnt <= '0;
          doneTag <= 2'b00;
          if (dcache_miss)      state <= ST_D_FILL;
          else if (dcache_wr)   state <= ST_WRITE;
          else if (icache_miss) state <= ST_I_FILL;
        end
        ST_D_FILL, ST_I_FILL: begin
          if (fillAccept && recvLast) begin
            state   <= ST_DONE;
            doneTag <= (state == ST_I_FILL) ? 2'b10 : 2'b01;
          end
        end
        ST_WRITE: begin
          if (waitCnt == WW'(MEM_LAT - 1)) state <= ST_DONE;
          else waitCnt <= waitCnt + WW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = issueNow || memWrNow;
  assign mem_wr    = memWrNow;
  assign mem_addr  = issueNow ? reqAddr + ADDR_W'({issueCnt, 1'b0})
                              : (memWrNow ? reqAddr : '0);
  assign mem_wdata = memWrNow ? reqData : '0;

  assign fill_data = fillAccept ? mem_rdata : '0;
  assign fill_word = fillAccept ? 3'(recvCnt) : 3'd0;
  assign fill_we_i = fillAccept && (state == ST_I_FILL);
  assign fill_we_d = fillAccept && (state == ST_D_FILL);
  assign tag_we_i  = (state == ST_DONE) && doneTag[1];
  assign tag_we_d  = (state == ST_DONE) && doneTag[0];

  assign busy    = (state != ST_IDLE);
  assign d_stall = dcache_miss || dcache_wr || (state == ST_D_FILL) || (state == ST_WRITE);
  assign i_stall = icache_miss || d_stall;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table-driven I fill, directed
// corner sequences and randomized request mixes against a transaction model.
module tb_cache_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0, dcache_miss = 1'b0, dcache_wr = 1'b0;
  logic [15:0] icache_miss_addr = '0, dcache_miss_addr = '0;
  logic [15:0] dcache_wr_addr = '0, dcache_wr_data = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d, i_stall, d_stall, busy;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word), .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .tag_we_i(tag_we_i), .tag_we_d(tag_we_d), .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
  );

  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] data; } memOp_t;
  typedef struct packed { logic side; logic [2:0] word; logic [15:0] data; } fill_t;
  typedef struct { int due; logic [15:0] addr; } pend_t;
  typedef struct { logic iMiss; logic [43:0] expOut; } vec_t;

  memOp_t obsMem[$], expMem[$];
  fill_t  obsFill[$], expFill[$];
  logic   obsTag[$], expTag[$];
  pend_t  pend[$];
  vec_t   tbl[15];

  int cyc = 0, nCmp = 0, nBad = 0;
  int stray, dStallCyc, dFall, iFall, startC, issues;
  bit logEn = 0, autoDrop = 0, countStray = 0, spurious = 0, done;

  function automatic logic [15:0] memVal(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [43:0] outVec();
    logic fw;
    fw = fill_we_i | fill_we_d;
    return {mem_en, mem_en & mem_wr, mem_en ? mem_addr : 16'h0, fill_we_i, fill_we_d,
            fw ? fill_word : 3'd0, fw ? fill_data : 16'h0, tag_we_i, tag_we_d,
            i_stall, d_stall, busy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    if (countStray && (fill_we_i || fill_we_d || tag_we_i || tag_we_d || mem_en)) stray++;
    if (mem_en && !mem_wr) pend.push_back('{cyc + 3, mem_addr});
    if (logEn) begin
      if (mem_en) obsMem.push_back({mem_wr, mem_addr, mem_wr ? mem_wdata : 16'h0});
      if (fill_we_i) obsFill.push_back({1'b1, fill_word, fill_data});
      if (fill_we_d) obsFill.push_back({1'b0, fill_word, fill_data});
      if (tag_we_i) obsTag.push_back(1'b1);
      if (tag_we_d) obsTag.push_back(1'b0);
      if (d_stall) dStallCyc++;
      if (cyc > startC && !d_stall && dFall < 0) dFall = cyc;
      if (cyc > startC && !i_stall && iFall < 0) iFall = cyc;
    end
    if (autoDrop) begin
      if (tag_we_i) icache_miss = 1'b0;
      if (tag_we_d) dcache_miss = 1'b0;
      if (mem_en && mem_wr) dcache_wr = 1'b0;
    end
  endtask

  // Memory model: a read issued in cycle t returns in cycle t+3.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata = memVal(pend[0].addr);
      pend.delete(0);
    end else if (spurious) begin
      mem_data_valid = 1'b1;
      mem_rdata = 16'($urandom);
    end
    #1;
    sample();
  endtask

  task automatic addFill(input logic side, input logic [15:0] a);
    logic [15:0] base, wa;
    base = a & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      wa = 16'(base + 2 * k);
      expMem.push_back({1'b0, wa, 16'h0});
      expFill.push_back({side, 3'(k), memVal(wa)});
    end
    expTag.push_back(side);
  endtask

  // Raise a set of requests together and hold each until it is serviced;
  // expected order D fill, store, I fill; 13 cycles per fill, 6 per store.
  task automatic serve(input string nm, input logic d, input logic w, input logic i,
                       input logic [15:0] da, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] ia);
    int expLen;
    obsMem.delete(); obsFill.delete(); obsTag.delete();
    expMem.delete(); expFill.delete(); expTag.delete();
    expLen = 0;
    if (d) begin addFill(1'b0, da); expLen += 13; end
    if (w) begin expMem.push_back({1'b1, wa, wd}); expLen += 6; end
    if (i) begin addFill(1'b1, ia); expLen += 13; end
    dcache_miss = d; dcache_miss_addr = da;
    dcache_wr = w; dcache_wr_addr = wa; dcache_wr_data = wd;
    icache_miss = i; icache_miss_addr = ia;
    logEn = 1; autoDrop = 1; dStallCyc = 0; dFall = -1; iFall = -1; startC = cyc;
    #1;
    sample();
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (!dcache_miss && !dcache_wr && !icache_miss && !busy) done = 1;
    end
    check({nm, "_complete"}, 64'(done), 64'(1));
    check({nm, "_cycles"}, 64'(cyc - startC), 64'(expLen));
    check({nm, "_nmem"}, 64'(obsMem.size()), 64'(expMem.size()));
    for (int k = 0; k < expMem.size() && k < obsMem.size(); k++)
      check($sformatf("%s_mem%0d", nm, k), 64'(obsMem[k]), 64'(expMem[k]));
    check({nm, "_nfill"}, 64'(obsFill.size()), 64'(expFill.size()));
    for (int k = 0; k < expFill.size() && k < obsFill.size(); k++)
      check($sformatf("%s_fill%0d", nm, k), 64'(obsFill[k]), 64'(expFill[k]));
    check({nm, "_ntag"}, 64'(obsTag.size()), 64'(expTag.size()));
    for (int k = 0; k < expTag.size() && k < obsTag.size(); k++)
      check($sformatf("%s_tag%0d", nm, k), 64'(obsTag[k]), 64'(expTag[k]));
    logEn = 0; autoDrop = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int m;
    // I fill of 0x0124: reads at cycles 1..8, data 4..11, tag at 12, idle at 13.
    for (int c = 0; c < 15; c++) begin
      logic en, fwe;
      logic [15:0] a, fd;
      logic [2:0] w;
      en  = (c >= 1 && c <= 8);
      a   = en ? 16'(16'h0120 + 2 * (c - 1)) : 16'h0;
      fwe = (c >= 4 && c <= 11);
      w   = fwe ? 3'(c - 4) : 3'd0;
      fd  = fwe ? memVal(16'(16'h0120 + 2 * (c - 4))) : 16'h0;
      tbl[c].iMiss  = (c <= 11);
      tbl[c].expOut = {en, 1'b0, a, fwe, 1'b0, w, fd, (c == 12), 1'b0, (c <= 11), 1'b0,
                       (c >= 1 && c <= 12)};
    end

    // Reset state
    #12;
    check("reset_outputs", 64'(outVec()), 64'(0));
    dcache_wr = 1'b1;
    #1;
    check("reset_stall_follow", 64'({d_stall, i_stall, busy, mem_en}), 64'(4'b1100));
    dcache_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // Table-driven I fill
    icache_miss_addr = 16'h0124;
    for (int c = 0; c < 15; c++) begin
      icache_miss = tbl[c].iMiss;
      #1;
      check($sformatf("ifill_c%0d", c), 64'(outVec()), 64'(tbl[c].expOut));
      tick();
    end

    // Store 0xBEEF to 0x0040
    serve("store", 1'b0, 1'b1, 1'b0, 16'h0, 16'h0040, 16'hBEEF, 16'h0);
    check("store_dstall_cycles", 64'(dStallCyc), 64'(5));

    // Simultaneous I and D misses
    serve("idsim", 1'b1, 1'b0, 1'b1, 16'h2468, 16'h0, 16'h0, 16'h1357);
    check("idsim_dfall", 64'(dFall - startC), 64'(13));
    check("idsim_ifall", 64'(iFall - startC), 64'(26));

    // Top-of-memory line
    serve("wrap", 1'b1, 1'b0, 1'b0, 16'hFFFA, 16'h0, 16'h0, 16'h0);

    // Spurious data while idle
    spurious = 1; countStray = 1; stray = 0;
    for (int k = 0; k < 5; k++) tick();
    check("spurious_stray", 64'(stray), 64'(0));
    check("spurious_busy", 64'(busy), 64'(0));
    spurious = 0; countStray = 0;

    // Reset asserted at the 4th fill issue
    icache_miss_addr = 16'h0300;
    icache_miss = 1'b1;
    issues = 0;
    for (int k = 0; k < 20 && issues < 4; k++) begin
      tick();
      if (mem_en && !mem_wr) issues++;
    end
    check("rst_4th_issue", 64'(issues), 64'(4));
    rst_n = 1'b0;
    #1;
    check("rst_async_out",
          64'({mem_en, busy, fill_we_i, fill_we_d, tag_we_i, tag_we_d}), 64'(0));
    check("rst_istall_held", 64'(i_stall), 64'(1));
    icache_miss = 1'b0;
    countStray = 1; stray = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("rst_late_data_stray", 64'(stray), 64'(0));
    countStray = 0;
    serve("postrst", 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0508);

    // Randomized request mixes
    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(1, 7);
      serve($sformatf("rnd%0d", r), m[0], m[1], m[2], 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
